// File: rtl/adder_tb_pkg.sv
// Shared types and constants for the adder self-check harness.
package adder_tb_pkg;

    localparam int N_DIRECTED = 8;

    // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        DIRECTED,
        RANDOM,
        DRAIN,
        DONE
    } harness_state_t;

    typedef struct packed {
        logic [31:0] x1;
        logic [31:0] x2;
    } operand_pair_t;

    localparam operand_pair_t CORNER_TABLE [N_DIRECTED] = '{
        '{32'h0000_0000, 32'h0000_0000},
        '{32'hFFFF_FFFF, 32'h0000_0001},
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{32'hAAAA_AAAA, 32'h5555_5555},
        '{32'h8000_0000, 32'h8000_0000},
        '{32'h7FFF_FFFF, 32'h0000_0001},
        '{32'h0000_0001, 32'hFFFF_FFFF},
        '{32'h5555_5555, 32'h5555_5555}
    };

    function automatic logic [31:0] lfsrNext(input logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with seed load; reset and load both restore the seed.
module lfsr32
    import adder_tb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    logic [31:0] state_q;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state_q <= seed;
        end else if (step) begin
            state_q <= lfsrNext(state_q);
        end
    end

    assign q = state_q;

endmodule

// File: rtl/adder_selfcheck_harness.sv
// Drives corner and pseudo-random operands into a 32-bit adder and checks
// every returned sum, keeping an error count and the first failing vector.
module adder_selfcheck_harness #(
    parameter int unsigned NUM_VECTORS = 1024,
    parameter int unsigned DUT_LATENCY = 0,
    parameter logic [31:0] SEED_A      = 32'hACE12468,
    parameter logic [31:0] SEED_B      = 32'h1357BDF9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] dut_x1,
    output logic [31:0] dut_x2,
    input  logic [31:0] dut_s,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx,
    output logic [31:0] first_err_got
);
    import adder_tb_pkg::*;

    localparam logic [15:0] LAST_DIRECTED = 16'(N_DIRECTED - 1);
    localparam logic [15:0] LAST_IDX      = 16'(N_DIRECTED + NUM_VECTORS - 1);
    localparam logic [2:0]  LAST_DRAIN    = 3'(DUT_LATENCY - 1);

    harness_state_t state_q, state_d;
    logic [15:0]    idx_q;
    logic [2:0]     drainCnt_q;
    logic [31:0]    dutX1_q, dutX2_q;
    logic           opValid_q;
    logic [31:0]    opExp_q;
    logic [15:0]    opIdx_q;
    logic           busy_q, done_q, pass_q;
    logic [15:0]    errCount_q, errCount_d;
    logic [15:0]    firstIdx_q;
    logic [31:0]    firstGot_q;

    logic           acceptStart, issue, lfsrStep, mismatch;
    logic [31:0]    vecX1, vecX2, lfsrA, lfsrB;
    operand_pair_t  cornerPair;
    logic           tailValid;
    logic [31:0]    tailExp;
    logic [15:0]    tailIdx;

    // DONE only re-arms once the final result has been folded into done/pass.
    assign acceptStart = start && ((state_q == IDLE) || ((state_q == DONE) && done_q));
    assign issue       = (state_q == DIRECTED) || (state_q == RANDOM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (acceptStart) state_d = DIRECTED;
            DIRECTED: if (idx_q == LAST_DIRECTED) state_d = RANDOM;
            RANDOM:   if (idx_q == LAST_IDX) state_d = (DUT_LATENCY == 0) ? DONE : DRAIN;
            DRAIN:    if (drainCnt_q == LAST_DRAIN) state_d = DONE;
            DONE:     if (acceptStart) state_d = DIRECTED;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        vecX1      = dutX1_q;
        vecX2      = dutX2_q;
        lfsrStep   = 1'b0;
        cornerPair = CORNER_TABLE[idx_q[2:0]];
        if (state_q == DIRECTED) begin
            vecX1 = cornerPair.x1;
            vecX2 = cornerPair.x2;
        end else if (state_q == RANDOM) begin
            vecX1    = lfsrA;
            vecX2    = lfsrB;
            lfsrStep = 1'b1;
        end
    end

    lfsr32 u_lfsrA (
        .clk  (clk),
        .rst  (rst),
        .load (acceptStart),
        .seed (SEED_A),
        .step (lfsrStep),
        .q    (lfsrA)
    );

    lfsr32 u_lfsrB (
        .clk  (clk),
        .rst  (rst),
        .load (acceptStart),
        .seed (SEED_B),
        .step (lfsrStep),
        .q    (lfsrB)
    );

    // Operand register: the expected sum and index travel alongside the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            dutX1_q    <= '0;
            dutX2_q    <= '0;
            opValid_q  <= 1'b0;
            opExp_q    <= '0;
            opIdx_q    <= '0;
            idx_q      <= '0;
            drainCnt_q <= '0;
        end else begin
            dutX1_q   <= vecX1;
            dutX2_q   <= vecX2;
            opValid_q <= issue;
            opExp_q   <= vecX1 + vecX2;
            opIdx_q   <= idx_q;
            if (acceptStart) begin
                idx_q <= '0;
            end else if (issue) begin
                idx_q <= idx_q + 16'd1;
            end
            drainCnt_q <= (state_q == DRAIN) ? drainCnt_q + 3'd1 : 3'd0;
        end
    end

    generate
        if (DUT_LATENCY == 0) begin : g_noDelay
            assign tailValid = opValid_q;
            assign tailExp   = opExp_q;
            assign tailIdx   = opIdx_q;
        end else begin : g_delay
            logic [DUT_LATENCY-1:0] dlValid_q;
            logic [31:0]            dlExp_q [DUT_LATENCY];
            logic [15:0]            dlIdx_q [DUT_LATENCY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    dlValid_q <= '0;
                end else begin
                    dlValid_q[0] <= opValid_q;
                    for (int j = 1; j < int'(DUT_LATENCY); j++) begin
                        dlValid_q[j] <= dlValid_q[j-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                dlExp_q[0] <= opExp_q;
                dlIdx_q[0] <= opIdx_q;
                for (int j = 1; j < int'(DUT_LATENCY); j++) begin
                    dlExp_q[j] <= dlExp_q[j-1];
                    dlIdx_q[j] <= dlIdx_q[j-1];
                end
            end

            assign tailValid = dlValid_q[DUT_LATENCY-1];
            assign tailExp   = dlExp_q[DUT_LATENCY-1];
            assign tailIdx   = dlIdx_q[DUT_LATENCY-1];
        end
    endgenerate

    assign mismatch = tailValid && (dut_s != tailExp);

    always_comb begin
        errCount_d = errCount_q;
        if (mismatch && (errCount_q != 16'hFFFF)) begin
            errCount_d = errCount_q + 16'd1;
        end
    end

    // The last compare lands on the same edge that raises done and pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            errCount_q <= '0;
            firstIdx_q <= '0;
            firstGot_q <= '0;
        end else if (acceptStart) begin
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            errCount_q <= '0;
            firstIdx_q <= '0;
            firstGot_q <= '0;
        end else begin
            errCount_q <= errCount_d;
            if (mismatch && (errCount_q == 16'd0)) begin
                firstIdx_q <= tailIdx;
                firstGot_q <= dut_s;
            end
            if ((state_q == DONE) && !done_q) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                pass_q <= (errCount_d == 16'd0);
            end
        end
    end

    assign dut_x1        = dutX1_q;
    assign dut_x2        = dutX2_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = errCount_q;
    assign first_err_idx = firstIdx_q;
    assign first_err_got = firstGot_q;

endmodule
